// File: rtl/pc_sequencer.sv
// Program-counter sequencer: HOLD/RUN/WAIT fetch FSM, priority next-PC mux and a circular return-address stack.
// Optional build macro PC_ALIGN_CHECK_EN: aligns redirect/exception targets to INC and pulses misalign.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_vector,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign
);

  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    WAIT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] count;

  logic             advance;
  logic             ras_has;
  logic             do_pop;
  logic             do_push;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] redirect_sel;
  logic [WIDTH-1:0] exc_sel;
  logic             redirect_mis;
  logic             exc_mis;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

  assign redirect_sel = redirect_target & ~ALIGN_MASK;
  assign exc_sel      = exc_vector & ~ALIGN_MASK;
  assign redirect_mis = |(redirect_target & ALIGN_MASK);
  assign exc_mis      = |(exc_vector & ALIGN_MASK);
`else
  assign redirect_sel = redirect_target;
  assign exc_sel      = exc_vector;
  assign redirect_mis = 1'b0;
  assign exc_mis      = 1'b0;
`endif

  assign advance   = fetch_valid & fetch_ready & ~stall;
  assign ras_has   = (count != '0);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_MAX);
  assign top_idx   = sp - PTR_ONE;
  assign ras_top   = ras_mem[top_idx];
  assign seq_pc    = pc + INC_W;
  assign do_pop    = advance & ~exc_valid & ret & ras_has;
  assign do_push   = advance & ~exc_valid & call;

  // pc_next is exactly what pc loads at the next non-reset edge, including the hold case.
  always_comb begin
    pc_next = pc;
    if (exc_valid) begin
      pc_next = exc_sel;
    end else if (advance) begin
      if (redirect_valid)
        pc_next = redirect_sel;
      else if (ret && ras_has)
        pc_next = ras_top;
      else
        pc_next = seq_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= HOLD;
      fetch_valid <= 1'b0;
      pc          <= RESET_VECTOR;
      sp          <= '0;
      count       <= '0;
      misalign    <= 1'b0;
    end else begin
      pc       <= pc_next;
      misalign <= exc_valid ? exc_mis : (advance & redirect_valid & redirect_mis);
      if (exc_valid) begin
        state       <= RUN;
        fetch_valid <= 1'b1;
        sp          <= '0;
        count       <= '0;
      end else begin
        case (state)
          HOLD: begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
          RUN:     if (!fetch_ready) state <= WAIT;
          WAIT:    if (fetch_ready)  state <= RUN;
          default: begin
            state       <= HOLD;
            fetch_valid <= 1'b0;
          end
        endcase
        // Circular storage: pushing when full simply overwrites the oldest slot.
        if (do_pop && !do_push) begin
          sp    <= top_idx;
          count <= count - CNT_ONE;
        end else if (do_push && !do_pop) begin
          sp <= sp + PTR_ONE;
          if (count != CNT_MAX)
            count <= count + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (do_push && do_pop)
        ras_mem[top_idx] <= seq_pc;
      else if (do_push)
        ras_mem[sp] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic against a queue-based reference model.
module tb_pc_sequencer;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        call;
  logic        ret;
  logic        exc_valid;
  logic [31:0] exc_vector;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign;

  pc_sequencer #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0),
    .INC(4),
    .RAS_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .call(call),
    .ret(ret),
    .exc_valid(exc_valid),
    .exc_vector(exc_vector),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .pc(pc),
    .pc_next(pc_next),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .misalign(misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] nxt;
    logic        fv;
    logic        em;
    logic        fu;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: PC value, whether fetching has started, and the return stack as a queue (back = top).
  logic [31:0] m_pc;
  bit          m_active;
  bit          m_mis;
  logic [31:0] m_ras[$];

  function automatic logic [31:0] align(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    return {t[31:2], 2'b00};
`else
    return t;
`endif
  endfunction

  function automatic bit misal(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_next(input bit fr, st, rv, input logic [31:0] rt,
                                             input bit r, ev, input logic [31:0] evec);
    if (ev) return align(evec);
    if (!(m_active && fr && !st)) return m_pc;
    if (rv) return align(rt);
    if (r && m_ras.size() > 0) return m_ras[m_ras.size()-1];
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc     = 32'h0;
    m_active = 1'b0;
    m_mis    = 1'b0;
    m_ras.delete();
  endtask

  task automatic cyc(input bit rst, fr, st, rv, input logic [31:0] rt,
                     input bit c, r, ev, input logic [31:0] evec);
    exp_t        e;
    logic [31:0] nxt;
    bit          adv;
    reset_n         = rst;
    fetch_ready     = fr;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    call            = c;
    ret             = r;
    exc_valid       = ev;
    exc_vector      = evec;
    nxt   = model_next(fr, st, rv, rt, r, ev, evec);
    e.pc  = m_pc;
    e.nxt = nxt;
    e.fv  = m_active;
    e.em  = (m_ras.size() == 0);
    e.fu  = (m_ras.size() == 4);
    e.mis = m_mis;
    sb.push_back(e);
    if (!rst) begin
      model_reset();
    end else if (ev) begin
      m_pc     = nxt;
      m_mis    = misal(evec);
      m_active = 1'b1;
      m_ras.delete();
    end else begin
      adv   = m_active && fr && !st;
      m_mis = adv && rv && misal(rt);
      if (adv) begin
        if (r && m_ras.size() > 0) void'(m_ras.pop_back());
        if (c) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end
      m_pc     = nxt;
      m_active = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic go();
    cyc(1, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: registered outputs and pc_next are stable at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("pc_next", pc_next, e.nxt);
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
        check("ras_empty", {31'b0, ras_empty}, {31'b0, e.em});
        check("ras_full", {31'b0, ras_full}, {31'b0, e.fu});
        check("misalign", {31'b0, misalign}, {31'b0, e.mis});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rt;
    logic [31:0] ev;
    bit          rst, fr, st, rv, c, r, ex;
    reset_n = 0; stall = 0; redirect_valid = 0; redirect_target = '0;
    call = 0; ret = 0; exc_valid = 0; exc_vector = '0; fetch_ready = 1;
    repeat (3) @(posedge clock);
    #1;
    model_reset();

    // Reset release and sequential fetch up to 0x10.
    for (int k = 0; k < 12 && !(m_active && m_pc == 32'h10); k++) go();
    // Three not-ready cycles at 0x10, then resume.
    repeat (3) cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 8 && m_pc != 32'h20; k++) go();
    // Call with redirect to 0x100, walk to 0x108, return.
    cyc(1, 1, 0, 1, 32'h100, 1, 0, 0, 32'h0);
    go();
    go();
    cyc(1, 1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
    go();
    // Five nested calls overflow the 4-entry stack, then five returns.
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 32'h400 + 32'h40 * i, 1, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
    go();
    // Call+ret together keeps occupancy; then exception during stall with redirect pending.
    cyc(1, 1, 0, 0, 32'h0, 1, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0, 1, 1, 0, 32'h0);
    cyc(1, 1, 1, 1, 32'h800, 0, 0, 1, 32'h1C);
    go();
    // Wrap from the top of the address space, and a misaligned redirect.
    cyc(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0);
    go();
    go();
    cyc(1, 1, 0, 1, 32'h103, 0, 0, 0, 32'h0);
    go();
    go();
    // Mid-run reset with WAIT and stack contents pending.
    cyc(1, 1, 0, 0, 32'h0, 1, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 1, 32'h500, 1, 1, 0, 32'h0);
    go();
    go();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      fr  = ($urandom_range(0, 99) < 80);
      st  = ($urandom_range(0, 99) < 15);
      rv  = ($urandom_range(0, 99) < 12);
      c   = ($urandom_range(0, 99) < 18);
      r   = ($urandom_range(0, 99) < 18);
      ex  = ($urandom_range(0, 99) < 3);
      rt  = $urandom;
      ev  = $urandom;
      if ($urandom_range(0, 9) < 7) rt[1:0] = 2'b00;
      if ($urandom_range(0, 9) < 7) ev[1:0] = 2'b00;
      cyc(rst, fr, st, rv, rt, c, r, ex, ev);
    end

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, PC value loaded at reset.
REQ-003 The block SHALL have parameter INC, default 4, sequential increment (power of two).
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 The block SHALL have port clock  in  1  single clock, all state updated on rising edge.
REQ-006 The block SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-007 The block SHALL have port stall  in  1  hold PC; no advance.
REQ-008 The block SHALL have port redirect_valid  in  1  take redirect_target on next advance.
REQ-009 The block SHALL have port redirect_target  in  WIDTH  branch target.
REQ-010 The block SHALL have port call  in  1  push return address pc+INC on advance.
REQ-011 The block SHALL have port ret  in  1  pop RAS top as next PC on advance.
REQ-012 The block SHALL have port exc_valid  in  1  exception request.
REQ-013 The block SHALL have port exc_vector  in  WIDTH  exception handler address.
REQ-014 The block SHALL have port fetch_ready  in  1  instruction memory accepts pc.
REQ-015 The block SHALL have port fetch_valid  out  1  pc is a valid fetch request.
REQ-016 The block SHALL have port pc  out  WIDTH  current PC register.
REQ-017 The block SHALL have port pc_next  out  WIDTH  combinational next-PC value.
REQ-018 The block SHALL have ports ras_empty and ras_full  out  1 each, RAS occupancy flags.
REQ-019 The block SHALL have port misalign  out  1  misaligned-target pulse.

Function
REQ-020 The FSM SHALL have states HOLD, RUN and WAIT; HOLD is entered on reset and has fetch_valid=0.
REQ-021 HOLD SHALL go to RUN after exactly one cycle; RUN and WAIT SHALL drive fetch_valid=1.
REQ-022 An advance SHALL occur when fetch_valid=1, fetch_ready=1 and stall=0.
REQ-023 RUN SHALL go to WAIT when fetch_ready=0, and WAIT SHALL return to RUN on fetch_ready=1; pc SHALL hold in WAIT.
REQ-024 On advance, pc SHALL load pc_next one cycle later; pc SHALL hold otherwise.
REQ-025 Next-PC priority SHALL be: exc_valid > redirect_valid > ret (RAS non-empty) > pc+INC.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH, so pc+INC wraps from all-ones region to 0.
REQ-027 exc_valid SHALL take effect regardless of stall, fetch_ready or state: next cycle pc=exc_vector, the RAS is flushed and the FSM goes to RUN.
REQ-028 call on advance SHALL push pc+INC.
REQ-029 When the RAS is full, a push SHALL overwrite the oldest entry and ras_full SHALL stay 1.
REQ-030 ret on advance with a non-empty RAS SHALL pop, with pc_next=top.
REQ-031 ret on an empty RAS SHALL leave the RAS unchanged and use the lower-priority source.
REQ-032 When call and ret are both asserted on advance, the top SHALL be popped as pc_next and then replaced by pc+INC, leaving occupancy unchanged.
REQ-033 When redirect_valid and ret are both asserted, redirect SHALL win and the RAS SHALL still pop.
REQ-034 call and ret SHALL be ignored when there is no advance or when exc_valid=1.

Reset
REQ-035 When reset_n=0 at a clock edge: pc=RESET_VECTOR, state=HOLD, fetch_valid=0, RAS empty (ras_empty=1, ras_full=0), misalign=0.
REQ-036 A reset asserted mid-operation SHALL discard the pending WAIT, redirect and RAS contents within the same edge.

Configuration
REQ-037 With macro PC_ALIGN_CHECK_EN defined, a selected redirect or exception target with nonzero low log2(INC) bits SHALL pulse misalign for one cycle and have those bits cleared before loading.
REQ-038 Without PC_ALIGN_CHECK_EN, misalign SHALL be tied 0 and targets SHALL be loaded unmodified.

Verification
REQ-039 Reset release, fetch_ready=1 -> one cycle fetch_valid=0, then pc 0x0, 0x4, 0x8 on successive cycles.
REQ-040 fetch_ready=0 for 3 cycles at pc=0x10 -> pc holds 0x10 for 3 cycles and advances to 0x14 after ready returns.
REQ-041 call with redirect to 0x100 at pc=0x20, then ret at 0x108 -> pc 0x100, 0x104, 0x108, 0x24.
REQ-042 Five calls with RAS_DEPTH=4 followed by five rets -> four correct returns in LIFO order, fifth ret sequential, ras_empty=1.
REQ-043 exc_valid with exc_vector=0x1C during stall=1 and pending redirect -> next pc=0x1C and ras_empty=1.
REQ-044 With PC_ALIGN_CHECK_EN, redirect to 0x103 -> pc=0x100 and a one-cycle misalign pulse.
